// File: rtl/ahbl_slv_mem.sv
// AHB-Lite slave memory: DW-bit word array with byte-lane writes, programmable wait states, two-cycle ERROR responses and saturating status counters.
// Latency: zero-wait transfers complete in the cycle after the address phase; wait_cfg adds that many low-hreadyout cycles; errors take two cycles.
// Backpressure: hreadyout is low during WAIT and ERR1; new address phases are only taken while hreadyout is high.
//
// Ports: hclk/hresetn clock and async active-low reset; AHB-Lite slave inputs
// (hsel, haddr, htrans, hsize, hburst, hprot, hwrite, hwdata, hready); wait_cfg
// wait states per transfer; outputs hreadyout, hresp, hrdata, xfer_cnt, err_cnt.
module ahbl_slv_mem #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 1024,
    parameter int CNT_W = 16
) (
    input  logic             hclk,
    input  logic             hresetn,
    input  logic             hsel,
    input  logic [AW-1:0]    haddr,
    input  logic [1:0]       htrans,
    input  logic [2:0]       hsize,
    input  logic [2:0]       hburst,
    input  logic [3:0]       hprot,
    input  logic             hwrite,
    input  logic [DW-1:0]    hwdata,
    input  logic             hready,
    input  logic [3:0]       wait_cfg,
    output logic             hreadyout,
    output logic             hresp,
    output logic [DW-1:0]    hrdata,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int NB = DW / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    localparam logic [AW:0] MEM_BYTES = (AW+1)'(DEPTH * NB);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t          state;
    logic [3:0]      wcnt;
    logic [AW-1:0]   haddr_q;
    logic [2:0]      hsize_q;
    logic            hwrite_q;
    logic [DW-1:0]   mem [DEPTH];

    // Only states that present hreadyout=1 can take a new address phase, so
    // stray master activity during WAIT/ERR1 never disturbs the transfer.
    logic accept;
    assign accept = hsel & hready & htrans[1] & hreadyout;

    logic [AW-1:0] amask;
    logic          addr_err;
    assign amask    = (AW'(1) << hsize) - AW'(1);
    assign addr_err = ({1'b0, haddr} >= MEM_BYTES) || (|(haddr & amask)) || (hsize > 3'(LB));

    logic [LB-1:0] boff;
    logic [IW-1:0] widx;
    logic [NB-1:0] be;
    assign boff = haddr_q[LB-1:0];
    assign widx = haddr_q[LB +: IW];

    always_comb begin
        be = '0;
        for (int b = 0; b < NB; b++) begin
            if (b >= int'(boff) && b < int'(boff) + (1 << hsize_q))
                be[b] = 1'b1;
        end
    end

    // Array is deliberately not reset; only a completing DATA cycle writes.
    always_ff @(posedge hclk) begin
        if (state == S_DATA && hwrite_q) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b])
                    mem[widx][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

    assign hrdata = (state == S_DATA && !hwrite_q) ? mem[widx] : '0;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= S_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            wcnt      <= '0;
            haddr_q   <= '0;
            hsize_q   <= '0;
            hwrite_q  <= 1'b0;
            xfer_cnt  <= '0;
            err_cnt   <= '0;
        end else begin
            if (state == S_DATA && xfer_cnt != '1)
                xfer_cnt <= xfer_cnt + 1'b1;
            if (state == S_ERR2 && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;

            case (state)
                S_IDLE, S_DATA, S_ERR2: begin
                    if (accept) begin
                        haddr_q  <= haddr;
                        hsize_q  <= hsize;
                        hwrite_q <= hwrite;
                        if (addr_err) begin
                            state     <= S_ERR1;
                            hreadyout <= 1'b0;
                            hresp     <= 1'b1;
                        end else if (wait_cfg != 4'd0) begin
                            state     <= S_WAIT;
                            hreadyout <= 1'b0;
                            hresp     <= 1'b0;
                            wcnt      <= wait_cfg - 4'd1;
                        end else begin
                            state     <= S_DATA;
                            hreadyout <= 1'b1;
                            hresp     <= 1'b0;
                        end
                    end else begin
                        state     <= S_IDLE;
                        hreadyout <= 1'b1;
                        hresp     <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (wcnt == 4'd0) begin
                        state     <= S_DATA;
                        hreadyout <= 1'b1;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    state     <= S_ERR2;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    hreadyout <= 1'b1;
                    hresp     <= 1'b0;
                end
            endcase
        end
    end

    // Burst type, protection and the BUSY bit carry no meaning for this slave.
    logic unused_ok;
    assign unused_ok = ^{hburst, hprot, htrans[0], haddr_q};

endmodule

// File: tb/tb_ahbl_slv_mem.sv
// Testbench for ahbl_slv_mem: table of AHB transfers driven through a pipelined master, responses scored against expected records.
// Latency: transfers are checked when hreadyout completes their data phase.
// Backpressure: the master holds its address phase while hreadyout is low.
module tb_ahbl_slv_mem;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             hclk = 1'b0;
    logic             hresetn;
    logic             hsel;
    logic [31:0]      haddr;
    logic [1:0]       htrans;
    logic [2:0]       hsize;
    logic [2:0]       hburst;
    logic [3:0]       hprot;
    logic             hwrite;
    logic [31:0]      hwdata;
    logic [3:0]       wait_cfg;
    logic             hreadyout;
    logic             hresp;
    logic [31:0]      hrdata;
    logic [CNT_W-1:0] xfer_cnt;
    logic [CNT_W-1:0] err_cnt;

    always #5 hclk = ~hclk;

    ahbl_slv_mem #(.AW(32), .DW(32), .DEPTH(1024), .CNT_W(CNT_W)) dut (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr),
        .htrans(htrans), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hwrite(hwrite), .hwdata(hwdata), .hready(hreadyout),
        .wait_cfg(wait_cfg), .hreadyout(hreadyout), .hresp(hresp),
        .hrdata(hrdata), .xfer_cnt(xfer_cnt), .err_cnt(err_cnt)
    );

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wcfg;
        logic        resp;   // expected hresp
        logic [31:0] rdata;  // expected hrdata at completion
    } vec_t;

    vec_t tbl[$];
    vec_t opq[$];
    vec_t sbq[$];

    int nvec = 0;
    int nerr = 0;
    int exp_xfer = 0;
    int exp_err = 0;

    function automatic vec_t mk(logic sel, logic [1:0] tr, logic wr, logic [31:0] a,
                                logic [2:0] sz, logic [31:0] wd, logic [3:0] wc,
                                logic rs, logic [31:0] rd);
        vec_t v;
        v.sel = sel; v.trans = tr; v.wr = wr; v.addr = a; v.size = sz;
        v.wdata = wd; v.wcfg = wc; v.resp = rs; v.rdata = rd;
        return v;
    endfunction

    function automatic int sat(int n);
        return (n > CMAX) ? CMAX : n;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_counters(string nm);
        chk({nm, "_xfer_cnt"}, 32'(xfer_cnt), 32'(sat(exp_xfer)));
        chk({nm, "_err_cnt"},  32'(err_cnt),  32'(sat(exp_err)));
    endtask

    task automatic chk_reset_outputs(string nm);
        chk({nm, "_hreadyout"}, 32'(hreadyout), 32'd1);
        chk({nm, "_hresp"},     32'(hresp),     32'd0);
        chk({nm, "_hrdata"},    hrdata,         32'd0);
        chk({nm, "_xfer_cnt"},  32'(xfer_cnt),  32'd0);
        chk({nm, "_err_cnt"},   32'(err_cnt),   32'd0);
    endtask

    // Pipelined master + monitor, called at a negedge with the bus idle.
    // Address N+1 is presented during the data phase of N; expected records
    // go into sbq at acceptance and are retired when hreadyout rises.
    task automatic run_ops(input int budget);
        bit   ap = 0;
        vec_t a;
        vec_t e;
        int   low = 0;
        bit   bad = 0;
        int   cyc = 0;
        int   exp_low;
        while ((ap || sbq.size() > 0 || opq.size() > 0) && cyc < budget) begin
            if (!ap && opq.size() > 0) begin
                a = opq.pop_front();
                ap = 1;
                hsel = a.sel; haddr = a.addr; htrans = a.trans; hsize = a.size;
                hwrite = a.wr; wait_cfg = a.wcfg;
                hburst = 3'($urandom_range(7)); hprot = 4'($urandom_range(15));
            end else if (!ap) begin
                hsel = 1'b0; htrans = 2'd0;
            end
            if (sbq.size() > 0) begin
                hwdata = sbq[0].wdata;
                if (!hreadyout) begin
                    low++;
                    if (hresp !== sbq[0].resp || hrdata !== 32'd0) bad = 1;
                end else begin
                    e = sbq.pop_front();
                    exp_low = e.resp ? 1 : int'(e.wcfg);
                    chk($sformatf("hresp@%h", e.addr), 32'(hresp), 32'(e.resp));
                    chk($sformatf("hrdata@%h", e.addr), hrdata, e.rdata);
                    chk($sformatf("wait_cycles@%h", e.addr), 32'(low), 32'(exp_low));
                    chk($sformatf("stall_outputs@%h", e.addr), 32'(bad), 32'd0);
                    if (e.resp) exp_err++; else exp_xfer++;
                end
            end
            if (hreadyout && ap) begin
                ap = 0;
                if (a.sel && a.trans[1]) begin
                    sbq.push_back(a);
                    low = 0;
                    bad = 0;
                end
            end
            @(posedge hclk);
            @(negedge hclk);
            cyc++;
        end
        if (cyc >= budget) begin
            chk("run_ops_timeout", 32'(cyc), 32'(budget - 1));
            sbq.delete();
            opq.delete();
        end
        hsel = 1'b0;
        htrans = 2'd0;
    endtask

    task automatic do_reset();
        hresetn = 1'b0;
        @(posedge hclk);
        @(negedge hclk);
        hresetn = 1'b1;
        exp_xfer = 0;
        exp_err = 0;
    endtask

    initial begin
        hsel = 0; haddr = 0; htrans = 0; hsize = 0; hburst = 0; hprot = 0;
        hwrite = 0; hwdata = 0; wait_cfg = 0; hresetn = 0;
        @(negedge hclk);
        #1;
        chk_reset_outputs("reset");
        @(negedge hclk);
        hresetn = 1'b1;

        //         sel tr   wr  addr          sz    wdata          wc  rs  rdata
        tbl.push_back(mk(1, 2'd2, 1, 32'h10,   3'd2, 32'hDEADBEEF, 0, 0, 32'h0));
        tbl.push_back(mk(1, 2'd2, 0, 32'h10,   3'd2, 32'h0,        0, 0, 32'hDEADBEEF));
        tbl.push_back(mk(1, 2'd2, 1, 32'h20,   3'd2, 32'h12345678, 0, 0, 32'h0));
        tbl.push_back(mk(1, 2'd2, 0, 32'h20,   3'd2, 32'h0,        3, 0, 32'h12345678));
        tbl.push_back(mk(1, 2'd2, 1, 32'h10,   3'd2, 32'h11223344, 0, 0, 32'h0));
        tbl.push_back(mk(1, 2'd2, 1, 32'h13,   3'd0, 32'hA5000000, 0, 0, 32'h0));
        tbl.push_back(mk(1, 2'd2, 0, 32'h10,   3'd2, 32'h0,        0, 0, 32'hA5223344));
        tbl.push_back(mk(1, 2'd2, 1, 32'h22,   3'd1, 32'hBEEF0000, 1, 0, 32'h0));
        tbl.push_back(mk(1, 2'd2, 1, 32'h21,   3'd0, 32'h0000CC00, 2, 0, 32'h0));
        tbl.push_back(mk(1, 2'd3, 0, 32'h20,   3'd2, 32'h0,        0, 0, 32'hBEEFCC78));
        tbl.push_back(mk(1, 2'd0, 1, 32'h20,   3'd2, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 2'd1, 1, 32'h20,   3'd2, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(0, 2'd2, 1, 32'h10,   3'd2, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 2'd2, 0, 32'h2,    3'd2, 32'h0,        0, 1, 32'h0));
        tbl.push_back(mk(1, 2'd2, 1, 32'h1000, 3'd2, 32'hFFFFFFFF, 0, 1, 32'h0));
        tbl.push_back(mk(1, 2'd2, 1, 32'h10,   3'd3, 32'hFFFFFFFF, 0, 1, 32'h0));
        tbl.push_back(mk(1, 2'd2, 1, 32'h12,   3'd2, 32'h00000000, 4, 1, 32'h0));
        tbl.push_back(mk(1, 2'd2, 0, 32'h10,   3'd2, 32'h0,        0, 0, 32'hA5223344));
        tbl.push_back(mk(1, 2'd2, 0, 32'h13,   3'd0, 32'h0,        0, 0, 32'hA5223344));
        tbl.push_back(mk(1, 2'd2, 1, 32'hFFC,  3'd2, 32'h0BADF00D, 0, 0, 32'h0));
        tbl.push_back(mk(1, 2'd2, 0, 32'hFFC,  3'd2, 32'h0,        0, 0, 32'h0BADF00D));

        for (int i = 0; i < tbl.size(); i++) opq.push_back(tbl[i]);
        run_ops(1000);
        chk_counters("table");

        // Reset in the middle of a waited write: nothing may be committed.
        opq.push_back(mk(1, 2'd2, 1, 32'h40, 3'd2, 32'h55AA55AA, 0, 0, 32'h0));
        run_ops(100);
        hsel = 1; haddr = 32'h40; htrans = 2'd2; hsize = 3'd2; hwrite = 1; wait_cfg = 4'd5;
        @(posedge hclk);
        @(negedge hclk);
        hsel = 0; htrans = 2'd0; hwdata = 32'h0;
        chk("mid_wait_hreadyout", 32'(hreadyout), 32'd0);
        @(posedge hclk);
        @(negedge hclk);
        hresetn = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge hclk);
        @(negedge hclk);
        hresetn = 1'b1;
        exp_xfer = 0;
        exp_err = 0;
        opq.push_back(mk(1, 2'd2, 0, 32'h40, 3'd2, 32'h0, 0, 0, 32'h55AA55AA));
        run_ops(100);
        chk_counters("after_abort");

        // Counter saturation, with idle/busy/deselected cycles in between.
        for (int i = 0; i < 9; i++)
            opq.push_back(mk(1, 2'd2, 0, 32'h40, 3'd2, 32'h0, 4'(i % 2), 0, 32'h55AA55AA));
        run_ops(200);
        chk_counters("ten_xfers");
        opq.push_back(mk(1, 2'd1, 0, 32'h40, 3'd2, 32'h0, 0, 0, 32'h0));
        opq.push_back(mk(1, 2'd0, 0, 32'h40, 3'd2, 32'h0, 0, 0, 32'h0));
        opq.push_back(mk(0, 2'd2, 0, 32'h40, 3'd2, 32'h0, 0, 0, 32'h0));
        opq.push_back(mk(1, 2'd1, 1, 32'h40, 3'd2, 32'h0, 0, 0, 32'h0));
        run_ops(100);
        chk_counters("idle_busy");
        for (int i = 0; i < 10; i++)
            opq.push_back(mk(1, 2'd2, 0, 32'h40, 3'd2, 32'h0, 0, 0, 32'h55AA55AA));
        run_ops(200);
        chk("xfer_cnt_saturated", 32'(xfer_cnt), 32'd15);
        chk_counters("saturated");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
